vga_ctrl: RTL and testbench

//  Timing controller that sequences the picture generator for 640x480@60 VGA.
//  - Runs free h/v counters and drives hsync/vsync.
//  - Issues pic_x/pic_y/pix_req one cycle ahead of the active pixel, which absorbs the generator's registered 1-cycle latency.
//  - Gates the returned pic_data onto rgb during the active region.
//  - Start/stop via en; a stop request always completes the current frame.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_if.sv | 30 +++
 rtl/vga_sync_cnt.sv | 47 ++++
 rtl/vga_ctrl.sv | 146 ++++++++++++++
 tb/tb_vga_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg -- shared definitions for the 640x480@60 VGA timing controller.
//   Timing constants: H_*/V_* in pixel clocks / lines, plus H_TOTAL, V_TOTAL.
//   Counter and pixel types (cnt_t, DATA_W), RGB565 colour constants,
//   and the controller FSM state encoding.
package vga_pkg;

  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int H_VALID = 640;
  localparam int H_FRONT = 16;
  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;  // 800

  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;
  localparam int V_VALID = 480;
  localparam int V_FRONT = 10;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;  // 525

  // Both totals fit in 10 bits, which is also the pic_x/pic_y width.
  localparam int CNT_W  = 10;
  localparam int DATA_W = 16;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [DATA_W-1:0] pixel_t;

  // RGB565 colours
  localparam pixel_t RGB_BLACK = 16'h0000;
  localparam pixel_t RGB_WHITE = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/vga_if.sv
// vga_if -- link between the timing controller, the picture generator and
// the display.
//   pic_x/pic_y/pix_req : pixel request to the generator
//   pic_data            : generator reply, one cycle after pix_req
//   hsync/vsync         : active-low syncs
//   rgb/rgb_valid       : gated pixel stream to the display
// Modports: master = controller, slave = generator/display side.
interface vga_if;
  import vga_pkg::*;

  cnt_t   pic_x;
  cnt_t   pic_y;
  logic   pix_req;
  pixel_t pic_data;
  logic   hsync;
  logic   vsync;
  pixel_t rgb;
  logic   rgb_valid;

  modport master (
    output pic_x, pic_y, pix_req, hsync, vsync, rgb, rgb_valid,
    input  pic_data
  );

  modport slave (
    input  pic_x, pic_y, pix_req, hsync, vsync, rgb, rgb_valid,
    output pic_data
  );

endinterface

// File: rtl/vga_sync_cnt.sv
// vga_sync_cnt -- free-running horizontal/vertical position counters.
//   vga_clk : pixel clock
//   rst     : asynchronous active-high reset (counters to 0,0)
//   clear   : hold both counters at 0 (controller idle)
//   h_cnt   : column 0..H_TOTAL-1
//   v_cnt   : line 0..V_TOTAL-1, steps when h_cnt wraps
//   last    : current position is the final pixel of the frame
module vga_sync_cnt
  import vga_pkg::*;
#(
  parameter int H_TOTAL = vga_pkg::H_TOTAL,
  parameter int V_TOTAL = vga_pkg::V_TOTAL
) (
  input  logic vga_clk,
  input  logic rst,
  input  logic clear,
  output cnt_t h_cnt,
  output cnt_t v_cnt,
  output logic last
);

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

  logic h_last;

  assign h_last = (h_cnt == H_LAST);
  assign last   = h_last && (v_cnt == V_LAST);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of process ordering.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (clear) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? cnt_t'(0) : v_cnt + cnt_t'(1);
    end else begin
      h_cnt <= h_cnt + cnt_t'(1);
    end
  end

endmodule

// File: rtl/vga_ctrl.sv
// vga_ctrl -- 640x480@60 VGA timing controller.
//   vga_clk     : pixel clock (25.175 MHz nominal)
//   rst         : asynchronous active-high reset
//   en          : 1 = run/resume, 0 = stop at the end of the current frame
//   bus         : vga_if.master -- pixel request, generator reply, syncs, rgb
//   frame_start : 1-cycle pulse at h=0, v=0 while running
//   busy        : controller is not idle
//   frame_cnt   : frames started, wraps at 16 bits
//                 (present only when VGA_CTRL_FRAME_CNT_EN is defined)
// Requests lead the active pixel by one cycle so the generator's registered
// reply lands exactly in the display window.
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int H_BACK  = vga_pkg::H_BACK,
  parameter int H_VALID = vga_pkg::H_VALID,
  parameter int H_FRONT = vga_pkg::H_FRONT,
  parameter int V_SYNC  = vga_pkg::V_SYNC,
  parameter int V_BACK  = vga_pkg::V_BACK,
  parameter int V_VALID = vga_pkg::V_VALID,
  parameter int V_FRONT = vga_pkg::V_FRONT
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        en,
  vga_if.master       bus,
  output logic        frame_start,
  output logic        busy
`ifdef VGA_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int HS      = H_SYNC + H_BACK;
  localparam int VS      = V_SYNC + V_BACK;

  localparam cnt_t H_SYNC_END = cnt_t'(H_SYNC);
  localparam cnt_t H_REQ_BEG  = cnt_t'(HS - 1);
  localparam cnt_t H_REQ_END  = cnt_t'(HS + H_VALID - 1);
  localparam cnt_t H_ACT_BEG  = cnt_t'(HS);
  localparam cnt_t H_ACT_END  = cnt_t'(HS + H_VALID);
  localparam cnt_t V_SYNC_END = cnt_t'(V_SYNC);
  localparam cnt_t V_ACT_BEG  = cnt_t'(VS);
  localparam cnt_t V_ACT_END  = cnt_t'(VS + V_VALID);

  state_t state;
  state_t state_nxt;
  cnt_t   h_cnt;
  cnt_t   v_cnt;
  logic   last;
  logic   active;
  logic   in_v;

  logic   hsync_c;
  logic   vsync_c;
  logic   pix_req_c;
  logic   rgb_valid_c;
  logic   frame_start_c;
  cnt_t   pic_x_c;
  cnt_t   pic_y_c;

  assign active = (state != ST_IDLE);

  // Idle holds the counters at 0 so the first running cycle is h=0, v=0.
  // Leaving RUN/DRAIN on the last pixel needs no explicit load: the wrap
  // already brings the counters to 0.
  vga_sync_cnt #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_sync_cnt (
    .vga_clk (vga_clk),
    .rst     (rst),
    .clear   (!active),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .last    (last)
  );

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // DRAIN only differs from RUN in what happens at the last pixel; a stop
  // request never truncates a frame, and re-raising en resumes in place.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (en) state_nxt = ST_RUN;
      ST_RUN:   if (!en) state_nxt = last ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (en)        state_nxt = ST_RUN;
        else if (last) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign in_v = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);

  // NOTE: every output gets its idle value first, so no path through the
  // block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    hsync_c       = 1'b1;
    vsync_c       = 1'b1;
    pix_req_c     = 1'b0;
    rgb_valid_c   = 1'b0;
    frame_start_c = 1'b0;
    pic_x_c       = '0;
    pic_y_c       = '0;
    if (active) begin
      hsync_c       = (h_cnt >= H_SYNC_END);
      vsync_c       = (v_cnt >= V_SYNC_END);
      pix_req_c     = in_v && (h_cnt >= H_REQ_BEG) && (h_cnt < H_REQ_END);
      rgb_valid_c   = in_v && (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
      frame_start_c = (h_cnt == '0) && (v_cnt == '0);
      if (pix_req_c) begin
        pic_x_c = h_cnt - H_REQ_BEG;
        pic_y_c = v_cnt - V_ACT_BEG;
      end
    end
  end

  assign bus.hsync     = hsync_c;
  assign bus.vsync     = vsync_c;
  assign bus.pix_req   = pix_req_c;
  assign bus.pic_x     = pic_x_c;
  assign bus.pic_y     = pic_y_c;
  assign bus.rgb_valid = rgb_valid_c;
  assign bus.rgb       = rgb_valid_c ? bus.pic_data : RGB_BLACK;
  assign frame_start   = frame_start_c;
  assign busy          = active;

`ifdef VGA_CTRL_FRAME_CNT_EN
  // Counts on the edge that ends the frame_start cycle; 16-bit wrap is free.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst)              frame_cnt <= '0;
    else if (frame_start) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_ctrl.sv
// tb_vga_ctrl -- self-checking bench for vga_ctrl.
// Horizontal timing is the real 800-clock line; the vertical timing is
// shortened to 10 lines (2 sync, 2 back, 4 active, 2 front) to keep frames
// short. A reference model tracks busy and the position within the frame;
// the stimulus pushes the expected pixel stream into a queue and a monitor
// pops one entry each time the DUT raises rgb_valid.
module tb_vga_ctrl;
  import vga_pkg::*;

  localparam int H_TOT  = 800;
  localparam int VSY    = 2;
  localparam int VBK    = 2;
  localparam int VVL    = 4;
  localparam int VFR    = 2;
  localparam int V_TOT  = VSY + VBK + VVL + VFR;  // 10
  localparam int VS_ROW = VSY + VBK;              // 4
  localparam int FRAME  = H_TOT * V_TOT;          // 8000

  logic vga_clk = 1'b0;
  logic rst     = 1'b1;
  logic en      = 1'b1;
  logic frame_start;
  logic busy;
`ifdef VGA_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  vga_if bus ();

  vga_ctrl #(
    .V_SYNC  (VSY),
    .V_BACK  (VBK),
    .V_VALID (VVL),
    .V_FRONT (VFR)
  ) dut (
    .vga_clk     (vga_clk),
    .rst         (rst),
    .en          (en),
    .bus         (bus),
    .frame_start (frame_start),
    .busy        (busy)
`ifdef VGA_CTRL_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  always #5 vga_clk = ~vga_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Picture generator: registered reply; all-ones when nothing is requested.
  always @(posedge vga_clk)
    bus.pic_data <= bus.pix_req ? {bus.pic_x, bus.pic_y[5:0]} : RGB_WHITE;

  // Reference model: busy flag, position in frame, frame counter.
  bit          m_busy = 1'b0;
  int          m_c    = 0;
  logic [15:0] m_fc   = '0;
  int unsigned cyc    = 0;

  always @(posedge vga_clk) cyc <= cyc + 1;

  always @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_c    <= 0;
      m_fc   <= '0;
    end else begin
      if (m_busy && m_c == 0) m_fc <= m_fc + 16'd1;
      if (!m_busy) begin
        if (en) begin
          m_busy <= 1'b1;
          m_c    <= 0;
        end
      end else if (m_c == FRAME - 1) begin
        m_c    <= 0;
        m_busy <= en;
      end else begin
        m_c <= m_c + 1;
      end
    end
  end

  // Scoreboard of expected rgb values, in display order.
  logic [15:0] exp_q[$];

  task automatic push_frame();
    for (int y = 0; y < VVL; y++)
      for (int x = 0; x < 640; x++)
        exp_q.push_back(16'((x << 6) | (y & 63)));
  endtask

  int unsigned prev_fs = 0;
  bit          have_prev = 1'b0;
  int          y_min = 1023;
  int          y_max = -1;

  // Monitor: compare every output against the model away from the clock edge.
  always @(negedge vga_clk) begin
    int h, v;
    bit in_v;
    logic [15:0] e;
    h = m_c % H_TOT;
    v = m_c / H_TOT;
    in_v = m_busy && (v >= VS_ROW) && (v < VS_ROW + VVL);

    check("busy", busy, m_busy);
    check("hsync", bus.hsync, !m_busy || h >= 96);
    check("vsync", bus.vsync, !m_busy || v >= VSY);
    check("frame_start", frame_start, m_busy && m_c == 0);
    check("pix_req", bus.pix_req, in_v && h >= 143 && h < 783);
    check("rgb_valid", bus.rgb_valid, in_v && h >= 144 && h < 784);
    check("pic_x", bus.pic_x, (in_v && h >= 143 && h < 783) ? h - 143 : 0);
    check("pic_y", bus.pic_y, (in_v && h >= 143 && h < 783) ? v - VS_ROW : 0);
`ifdef VGA_CTRL_FRAME_CNT_EN
    check("frame_cnt", frame_cnt, m_fc);
`endif

    // Boundary points on the first active line, with literal expectations.
    if (m_busy && v == VS_ROW) begin
      case (h)
        95:  check("hsync_low_h95", bus.hsync, 0);
        96:  check("hsync_high_h96", bus.hsync, 1);
        142: check("pix_req_low_h142", bus.pix_req, 0);
        143: begin
          check("pix_req_rise_h143", bus.pix_req, 1);
          check("pic_x_h143", bus.pic_x, 0);
        end
        144: check("rgb_valid_h144", bus.rgb_valid, 1);
        782: check("pic_x_h782", bus.pic_x, 639);
        783: begin
          check("pix_req_fall_h783", bus.pix_req, 0);
          check("rgb_valid_h783", bus.rgb_valid, 1);
        end
        784: check("rgb_valid_h784", bus.rgb_valid, 0);
        default: ;
      endcase
    end

    if (bus.rgb_valid) begin
      if (exp_q.size() == 0) begin
        check("rgb_unexpected_valid", bus.rgb_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("rgb_data", bus.rgb, e);
      end
    end else begin
      check("rgb_zero", bus.rgb, 0);
    end

    if (bus.pix_req) begin
      if (int'(bus.pic_y) < y_min) y_min = int'(bus.pic_y);
      if (int'(bus.pic_y) > y_max) y_max = int'(bus.pic_y);
    end

    if (frame_start) begin
      if (have_prev) check("frame_start_period", cyc - prev_fs, FRAME);
      prev_fs   = cyc;
      have_prev = 1'b1;
    end
    if (!busy) have_prev = 1'b0;
  end

  // Advance to the next cycle the model places at (h, v), then step #1
  // past the sampling edge so inputs can be driven.
  task automatic wait_at(input int h, input int v);
    int target;
    bit hit;
    target = v * H_TOT + h;
    hit = 1'b0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      @(negedge vga_clk);
      if (m_busy && m_c == target) hit = 1'b1;
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_at: position h=%0d v=%0d not reached", h, v);
    end
    #1;
  endtask

  initial begin
    for (int f = 0; f < 5; f++) push_frame();

    // Reset held for 3 cycles with en=1.
    repeat (3) begin
      @(negedge vga_clk);
      check("rst_hsync", bus.hsync, 1);
      check("rst_vsync", bus.vsync, 1);
      check("rst_rgb", bus.rgb, 0);
      check("rst_busy", busy, 0);
    end
    #1 rst = 1'b0;
    @(negedge vga_clk);
    check("frame_start_after_rst", frame_start, 1);

    // Frames 1..3 with en high; frame 4 starts after three full periods.
    repeat (3) wait_at(0, 0);
`ifdef VGA_CTRL_FRAME_CNT_EN
    check("frame_cnt_3frames", frame_cnt, 3);
`endif

    // Frame 4: stop request mid-frame, then resume while draining.
    wait_at(300, 5);
    en = 1'b0;
    wait_at(500, 7);
    check("busy_in_drain", busy, 1);
    en = 1'b1;
    wait_at(0, 0);
    check("frame_start_after_resume", frame_start, 1);

    // Frame 5: several toggles, final level low -> completes, then idle.
    wait_at(300, 5);
    en = 1'b0;
    wait_at(10, 6);
    en = 1'b1;
    wait_at(600, 8);
    en = 1'b0;
    wait_at(799, 9);
    check("busy_last_pixel", busy, 1);
    @(negedge vga_clk);
    check("idle_busy", busy, 0);
    check("idle_hsync", bus.hsync, 1);
    check("idle_vsync", bus.vsync, 1);
    check("idle_pix_req", bus.pix_req, 0);
    repeat (20) @(negedge vga_clk);

    // Frame 6: stop request arriving exactly on the last pixel.
    push_frame();
    #1 en = 1'b1;
    wait_at(0, 0);
    check("frame_start_restart", frame_start, 1);
    wait_at(799, 9);
    en = 1'b0;
    @(negedge vga_clk);
    check("idle_after_last_busy", busy, 0);
    check("idle_after_last_fs", frame_start, 0);
    repeat (10) @(negedge vga_clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("pic_y_min", y_min, 0);
    check("pic_y_max", y_max, VVL - 1);

    // Frame 7: reset in the middle of the active region.
    push_frame();
    #1 en = 1'b1;
    wait_at(300, 5);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_hsync", bus.hsync, 1);
    check("midrst_vsync", bus.vsync, 1);
    check("midrst_pix_req", bus.pix_req, 0);
    check("midrst_rgb_valid", bus.rgb_valid, 0);
`ifdef VGA_CTRL_FRAME_CNT_EN
    check("midrst_frame_cnt", frame_cnt, 0);
`endif
    exp_q.delete();
    en = 1'b0;
    repeat (2) @(negedge vga_clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge vga_clk);
    check("post_rst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
